// File: rtl/dif_butterfly_seq_if.sv
// Handshake bundle for the sequential DIF butterfly: operand set in
// (A/B/W with valid/ready) and result pair out (X/Y with valid/ready).
interface dif_butterfly_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] W;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] X;
    logic [N-1:0] Y;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, A, B, W, out_ready,
        input  in_ready, out_valid, X, Y
    );

    // The butterfly itself.
    modport slave (
        input  in_valid, A, B, W, out_ready,
        output in_ready, out_valid, X, Y
    );
endinterface

// File: rtl/dif_butterfly_seq.sv
// Radix-2 DIF butterfly: X = (A+B)>>>SCALE, Y = ((A-B)*W)>>>SCALE on packed
// complex words {re, im}. One shared H x H signed multiplier is stepped
// through the four real partial products, one per M_* state.
module dif_butterfly_seq #(
    parameter int N     = 32,
    parameter int Q     = 8,
    parameter int SCALE = 0
) (
    input  logic               clk,
    input  logic               reset,
    dif_butterfly_seq_if.slave bus
);
    localparam int H = N / 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M_RR = 3'd1,
        M_II = 3'd2,
        M_RI = 3'd3,
        M_IR = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   w_q, w_d;
    logic [N-1:0]   s_q, s_d;
    logic [H-1:0]   dr_q, dr_d;
    logic [H-1:0]   di_q, di_d;
    logic [H-1:0]   acc_r_q, acc_r_d;
    logic [H-1:0]   acc_i_q, acc_i_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;

    logic [H-1:0]          mul_a, mul_b;
    logic signed [2*H-1:0] prod_full;
    logic [H-1:0]          prod_keep;
    logic [H-1:0]          acc_i_fin;
    logic                  unused_prod;

    logic                  accept;
    logic [N-1:0]          s_new;
    logic [H-1:0]          dr_new, di_new;

    // Per-component arithmetic shift used for the optional IFFT halving.
    function automatic logic [H-1:0] asr(input logic [H-1:0] v);
        return $signed(v) >>> SCALE;
    endfunction

    // Ready only when idle or when the held result is leaving this cycle;
    // forced low during reset so nothing is taken while being cleared.
    assign bus.in_ready  = reset && ((state_q == IDLE) ||
                                     ((state_q == OUT) && bus.out_ready));
    assign accept        = bus.in_ready && bus.in_valid;
    assign bus.out_valid = (state_q == OUT);
    assign bus.X         = x_q;
    assign bus.Y         = y_q;

    // Sum and difference are formed at accept time; only W and these are kept.
    assign s_new  = {bus.A[N-1:H] + bus.B[N-1:H], bus.A[H-1:0] + bus.B[H-1:0]};
    assign dr_new = bus.A[N-1:H] - bus.B[N-1:H];
    assign di_new = bus.A[H-1:0] - bus.B[H-1:0];

    // Multiplier operand select depends on state alone.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            M_RR: begin mul_a = dr_q; mul_b = w_q[N-1:H]; end
            M_II: begin mul_a = di_q; mul_b = w_q[H-1:0]; end
            M_RI: begin mul_a = dr_q; mul_b = w_q[H-1:0]; end
            M_IR: begin mul_a = di_q; mul_b = w_q[N-1:H]; end
            default: ;
        endcase
    end

    // Full signed product; keeping bits [H-1+Q:Q] floors toward -inf.
    assign prod_full   = $signed({{H{mul_a[H-1]}}, mul_a}) *
                         $signed({{H{mul_b[H-1]}}, mul_b});
    assign prod_keep   = prod_full[H-1+Q:Q];
    assign unused_prod = ^prod_full;
    assign acc_i_fin   = acc_i_q + prod_keep;

    // Next-state and datapath updates; defaults hold every register.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        dr_d    = dr_q;
        di_d    = di_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        x_d     = x_q;
        y_d     = y_q;

        if (accept) begin
            w_d  = bus.W;
            s_d  = s_new;
            dr_d = dr_new;
            di_d = di_new;
        end

        case (state_q)
            IDLE: if (accept) state_d = M_RR;
            M_RR: begin
                acc_r_d = prod_keep;
                state_d = M_II;
            end
            M_II: begin
                acc_r_d = acc_r_q - prod_keep;
                state_d = M_RI;
            end
            M_RI: begin
                acc_i_d = prod_keep;
                state_d = M_IR;
            end
            M_IR: begin
                acc_i_d = acc_i_fin;
                x_d     = {asr(s_q[N-1:H]), asr(s_q[H-1:0])};
                y_d     = {asr(acc_r_q), asr(acc_i_fin)};
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = accept ? M_RR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= '0;
            dr_q    <= '0;
            di_q    <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            dr_q    <= dr_d;
            di_q    <= di_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
endmodule
